cnt_selector: RTL and testbench

Selects one of two count buses, CNT1 or CNT2, and drives it onto a registered output CNT, under control of a slide-switch input SW. The block sits between two counter blocks and the display/ALU path on the FPGA board. SW is an asynchronous, bouncy board input, so the block synchronizes and debounces it before it changes the selection. The selection change is glitch-free, and the block reports each change with a one-cycle pulse.

---
 rtl/cnt_selector_pkg.sv | 12 +
 rtl/cnt_selector_sw_debounce.sv | 63 ++++++
 rtl/cnt_selector.sv | 47 ++++
 tb/tb_cnt_selector.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/cnt_selector_pkg.sv
// Shared constants for the count selector and its switch debouncer.
package cnt_selector_pkg;

  localparam int unsigned CNT_WIDTH_DEFAULT       = 4;
  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 4;

  // One spare bit keeps the terminal count representable for any cycle count.
  function automatic int unsigned dbnc_cnt_width(input int unsigned cycles);
    return $clog2(cycles) + 1;
  endfunction

endpackage

// File: rtl/cnt_selector_sw_debounce.sv
// Two-flop synchronizer plus debounce counter for the board slide switch;
// produces the debounced selection and a one-cycle change pulse.
module sw_debounce
  import cnt_selector_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic CLK,
  input  logic RSTN,
  input  logic SW,
  output logic SEL,
  output logic CHG
);

  localparam int unsigned    CW       = dbnc_cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1_q, s1_d;
  logic          s2_q, s2_d;
  logic          sel_q, sel_d;
  logic          chg_q, chg_d;
  logic [CW-1:0] dbnc_q, dbnc_d;

  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path
    // leaves one unassigned and no latch is inferred.
    s1_d   = SW;
    s2_d   = s1_q;
    sel_d  = sel_q;
    chg_d  = 1'b0;
    dbnc_d = '0;
    if (s2_q != sel_q) begin
      if (dbnc_q == CNT_LAST) begin
        sel_d = s2_q;
        chg_d = 1'b1;
      end else begin
        dbnc_d = dbnc_q + 1'b1;
      end
    end
  end

  // NOTE: non-blocking assignments make every flop sample pre-edge values,
  // which is what gives the synchronizer its two distinct stages.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      sel_q  <= 1'b0;
      chg_q  <= 1'b0;
      dbnc_q <= '0;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      sel_q  <= sel_d;
      chg_q  <= chg_d;
      dbnc_q <= dbnc_d;
    end
  end

  assign SEL = sel_q;
  assign CHG = chg_q;

endmodule

// File: rtl/cnt_selector.sv
// Registered two-way count mux steered by a synchronized, debounced switch.
module cnt_selector
  import cnt_selector_pkg::*;
#(
  parameter int unsigned WIDTH           = CNT_WIDTH_DEFAULT,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic             SW,
  input  logic [WIDTH-1:0] CNT1,
  input  logic [WIDTH-1:0] CNT2,
  output logic [WIDTH-1:0] CNT,
  output logic             SEL,
  output logic             CHG
);

  logic             sel;
  logic [WIDTH-1:0] cnt_q, cnt_d;

  sw_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_sw_debounce (
    .CLK (CLK),
    .RSTN(RSTN),
    .SW  (SW),
    .SEL (sel),
    .CHG (CHG)
  );

  // Steered by the registered selection, so CNT always holds one whole source.
  always_comb begin
    cnt_d = sel ? CNT2 : CNT1;
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign CNT = cnt_q;
  assign SEL = sel;

endmodule

// File: tb/tb_cnt_selector.sv
// Randomized bench for cnt_selector against a sample-history reference model.
module tb_cnt_selector;

  localparam int W = 4;
  localparam int D = 4;

  logic         CLK  = 1'b0;
  logic         RSTN = 1'b0;
  logic         SW   = 1'b0;
  logic [W-1:0] CNT1 = '0;
  logic [W-1:0] CNT2 = '0;
  logic [W-1:0] CNT;
  logic         SEL;
  logic         CHG;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 CLK = ~CLK;

  cnt_selector #(
    .WIDTH          (W),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .CLK (CLK),
    .RSTN(RSTN),
    .SW  (SW),
    .CNT1(CNT1),
    .CNT2(CNT2),
    .CNT (CNT),
    .SEL (SEL),
    .CHG (CHG)
  );

  // Reference model: the selection flips once the last D synchronized
  // observations since the previous flip (or reset) all disagree with it.
  bit           sw_hist[$];
  bit           obs[$];
  bit           sel_m;
  bit           chg_m;
  logic [W-1:0] cnt_m;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  function automatic void model_reset();
    sw_hist = '{1'b0, 1'b0};
    obs.delete();
    sel_m = 1'b0;
    chg_m = 1'b0;
    cnt_m = '0;
  endfunction

  function automatic void model_edge();
    bit s2_seen;
    bit all_differ;
    s2_seen = sw_hist[0];
    sw_hist.push_back(SW);
    void'(sw_hist.pop_front());
    cnt_m = sel_m ? CNT2 : CNT1;
    chg_m = 1'b0;
    obs.push_back(s2_seen);
    if (obs.size() >= D) begin
      all_differ = 1'b1;
      for (int i = obs.size() - D; i < obs.size(); i++)
        if (obs[i] == sel_m) all_differ = 1'b0;
      if (all_differ) begin
        sel_m = ~sel_m;
        chg_m = 1'b1;
        obs.delete();
      end
    end
    if (obs.size() > 16) void'(obs.pop_front());
  endfunction

  task automatic step();
    @(posedge CLK);
    model_edge();
    #1;
    check("sel", SEL, sel_m);
    check("chg", CHG, chg_m);
    check("cnt", CNT, cnt_m);
  endtask

  task automatic check_in_reset(input string tag);
    check({tag, "_cnt"}, CNT, '0);
    check({tag, "_sel"}, SEL, 1'b0);
    check({tag, "_chg"}, CHG, 1'b0);
  endtask

  // SW must already hold its new level; the next edge is the first one to sample it.
  task automatic measure_switch(input string tag, input bit target);
    int chg_at = -1;
    int pulses = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (CHG) begin
        pulses++;
        if (chg_at < 0) chg_at = i;
      end
    end
    check({tag, "_latency"}, chg_at, D + 1);
    check({tag, "_pulses"}, pulses, 1);
    check({tag, "_sel"}, SEL, target);
    check({tag, "_cnt"}, CNT, target ? CNT2 : CNT1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_reset();
    CNT1 = 4'b1100;
    CNT2 = 4'b0011;
    SW   = 1'b0;
    RSTN = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    check_in_reset("rst");
    RSTN = 1'b1;
    step();
    check("first_cnt", CNT, 4'b1100);
    repeat (2) step();

    // Short excursion must be rejected.
    SW = 1'b1;
    repeat (D - 1) step();
    SW = 1'b0;
    repeat (8) step();
    check("bounce_sel", SEL, 1'b0);
    check("bounce_cnt", CNT, 4'b1100);

    SW = 1'b1;
    measure_switch("to_cnt2", 1'b1);
    check("to_cnt2_val", CNT, 4'b0011);

    CNT2 = 4'b1010;
    step();
    check("cnt2_follow", CNT, 4'b1010);
    CNT1 = 4'b0101;
    step();
    check("cnt1_ignored", CNT, 4'b1010);

    SW = 1'b0;
    measure_switch("to_cnt1", 1'b0);
    check("to_cnt1_val", CNT, 4'b0101);

    // Reset while a switch to CNT2 is being counted, SW held through reset.
    SW = 1'b1;
    repeat (3) step();
    #2 RSTN = 1'b0;
    model_reset();
    #1;
    check_in_reset("midrst");
    @(posedge CLK);
    #1;
    check_in_reset("midrst_hold");
    RSTN = 1'b1;
    measure_switch("after_rst", 1'b1);

    for (int r = 0; r < 60; r++) begin
      int len;
      len = $urandom_range(1, 2 * D + 1);
      SW  = 1'($urandom_range(0, 1));
      for (int c = 0; c < len; c++) begin
        CNT1 = W'($urandom_range(0, 15));
        CNT2 = W'($urandom_range(0, 15));
        step();
      end
      if ($urandom_range(0, 19) == 0) begin
        RSTN = 1'b0;
        model_reset();
        #1;
        check_in_reset("rnd_rst");
        @(posedge CLK);
        #1;
        RSTN = 1'b1;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
